// File: rtl/usb_bs_pkg.sv
// Shared types and defaults for the bit-stuffing engine.
// Holds the FSM state encoding, default geometry constants, and the helper
// used to size the run and bit-index counters.
package usb_bs_pkg;

    // Engine states: waiting for a source, passing PID bits through unchanged,
    // counting runs of 1s, and emitting one stuffed 0.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_COUNT = 2'd2,
        ST_STUFF = 2'd3
    } bs_state_e;

    localparam int DEF_NUM_SRC   = 2;
    localparam int DEF_RUN_LEN   = 6;
    localparam int DEF_SKIP_BITS = 8;
    localparam int DEF_STUFF_W   = 8;

    // Bits needed for a counter whose value range is 0..n-1.
    // Callers pass (max_value + 1), so the counter can hold max_value.
    // It never returns less than 1, so a zero-range counter stays declarable.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bs_src_arbiter.sv
// Source selection for the bit-stuffing engine.
// While unlocked (engine idle), the lowest-index valid source is presented
// combinationally and captured every cycle. While locked (a packet is in
// flight), the captured index is held so other sources cannot interrupt.
module bs_src_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_valid,
    input  logic               i_locked,
    output logic [SEL_W-1:0]   o_sel
);

    logic [SEL_W-1:0] w_pick;
    logic [SEL_W-1:0] r_sel;

    // Fixed priority pick: the lowest valid index wins.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                w_pick = SEL_W'(i);
            end
        end
    end

    // Track the pick while unlocked, then freeze it for the packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel <= '0;
        end else if (!i_locked) begin
            r_sel <= w_pick;
        end
    end

    assign o_sel = i_locked ? r_sel : w_pick;

endmodule

// File: rtl/bitstuff_engine.sv
// Serial bit-stuffing engine.
// Locks onto one of NUM_SRC serial sources and streams its bits out with
// zero latency. The first SKIP_BITS bits of a packet pass through untouched.
// After that, every RUN_LEN consecutive 1s cause a stuffed 0 to be inserted,
// and the source is stalled for that cycle. A packet ends when the selected
// source drops valid. If a run completes on the last bit, the trailing
// stuffed 0 is still emitted before returning to idle.
//
// Handshake: on a given cycle a bit moves from source s to the output exactly
// when src_valid[s] && src_ready[s]. That bit appears on out_bit in the same
// cycle, with out_valid high. A stuffed cycle shows out_valid high while every
// src_ready is low.
module bitstuff_engine
    import usb_bs_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int RUN_LEN   = DEF_RUN_LEN,
    parameter int SKIP_BITS = DEF_SKIP_BITS,
    parameter int STUFF_W   = DEF_STUFF_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_valid,
    input  logic [NUM_SRC-1:0] src_bit,
    output logic [NUM_SRC-1:0] src_ready,
    output logic               out_bit,
    output logic               out_valid,
    output logic [STUFF_W-1:0] stuff_cnt,
    output logic               pkt_done,
    output bs_state_e          dbg_state
);

    localparam int RUN_W = cnt_width(RUN_LEN + 1);
    localparam int IDX_W = cnt_width(SKIP_BITS + 1);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
    localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(SKIP_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((SKIP_BITS > 0) ? SKIP_BITS - 1 : 0);

    bs_state_e        r_state;
    bs_state_e        w_next_state;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W-1:0] w_run_inc;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [STUFF_W-1:0] r_stuff_cnt;
    logic [STUFF_W-1:0] w_stuff_next;

    logic [SEL_W-1:0] w_sel;
    logic             w_sel_valid;
    logic             w_sel_bit;
    logic             w_locked;

    // The selection stays open only in IDLE; in every other state the
    // captured source index is held.
    assign w_locked = (r_state != ST_IDLE);

    bs_src_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_arbiter (
        .i_clk    (clock),
        .i_rst_n  (reset_n),
        .i_valid  (src_valid),
        .i_locked (w_locked),
        .o_sel    (w_sel)
    );

    // In IDLE w_sel is the live priority pick, so w_sel_valid there means
    // "some source is valid"; in a packet it is the locked source's valid.
    assign w_sel_valid = src_valid[w_sel];
    assign w_sel_bit   = src_bit[w_sel];
    assign w_run_inc   = r_run + 1'b1;

    // State register plus the run, bit-index and stuff counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_run       <= '0;
            r_idx       <= '0;
            r_stuff_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_run       <= w_run_next;
            r_idx       <= w_idx_next;
            r_stuff_cnt <= w_stuff_next;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        w_next_state = r_state;
        w_run_next   = r_run;
        w_idx_next   = r_idx;
        w_stuff_next = r_stuff_cnt;
        case (r_state)
            ST_IDLE, ST_SKIP, ST_COUNT: begin
                if (w_sel_valid) begin
                    // A packet start resets the count shown for the packet.
                    if (r_state == ST_IDLE) begin
                        w_stuff_next = '0;
                    end
                    if (r_idx < IDX_SAT) begin
                        // PID region: bits pass through and the run stays at 0.
                        // r_idx is always 0 in IDLE, so a packet start lands
                        // here whenever SKIP_BITS > 0.
                        w_run_next   = '0;
                        w_idx_next   = r_idx + 1'b1;
                        w_next_state = (r_idx < IDX_LAST) ? ST_SKIP : ST_COUNT;
                    end else if (w_sel_bit) begin
                        if (w_run_inc == RUN_MAX) begin
                            w_run_next   = '0;
                            w_next_state = ST_STUFF;
                        end else begin
                            w_run_next   = w_run_inc;
                            w_next_state = ST_COUNT;
                        end
                    end else begin
                        w_run_next   = '0;
                        w_next_state = ST_COUNT;
                    end
                end else if (r_state != ST_IDLE) begin
                    // The selected source dropped valid, so the packet ends.
                    w_next_state = ST_IDLE;
                    w_run_next   = '0;
                    w_idx_next   = '0;
                end
            end
            ST_STUFF: begin
                if (r_stuff_cnt != {STUFF_W{1'b1}}) begin
                    w_stuff_next = r_stuff_cnt + 1'b1;
                end
                w_run_next = '0;
                if (w_sel_valid) begin
                    w_next_state = ST_COUNT;
                end else begin
                    w_next_state = ST_IDLE;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_run_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // Output decode. Outputs are forced low while reset is asserted, so an
    // active source cannot leak through during reset.
    always_comb begin
        src_ready = '0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        pkt_done  = 1'b0;
        if (reset_n) begin
            case (r_state)
                ST_IDLE, ST_SKIP, ST_COUNT: begin
                    if (w_sel_valid) begin
                        src_ready[w_sel] = 1'b1;
                        out_valid        = 1'b1;
                        out_bit          = w_sel_bit;
                    end else if (r_state != ST_IDLE) begin
                        pkt_done = 1'b1;
                    end
                end
                ST_STUFF: begin
                    out_valid = 1'b1;
                    out_bit   = 1'b0;
                    pkt_done  = !w_sel_valid;
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    assign stuff_cnt = r_stuff_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bitstuff_engine.sv
// Directed bench for bitstuff_engine.
// dut_a uses the default geometry. dut_b uses RUN_LEN=3 and SKIP_BITS=0.
// Both DUTs share clock, reset and source inputs; each phase checks one of
// them. Inputs change on the falling edge, and outputs are checked 1 time
// unit later as {src_ready[1:0], out_valid, out_bit, pkt_done}.
module tb_bitstuff_engine;
    import usb_bs_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] src_valid = 2'b00;
    logic [1:0] src_bit = 2'b00;

    logic [1:0] a_ready, b_ready;
    logic       a_ob, a_ov, a_done, b_ob, b_ov, b_done;
    logic [7:0] a_cnt, b_cnt;
    bs_state_e  a_st, b_st;

    int total = 0;
    int bad = 0;

    localparam logic [4:0] E_IDLE      = 5'b00000;
    localparam logic [4:0] E_P0_1      = 5'b01110;
    localparam logic [4:0] E_P0_0      = 5'b01100;
    localparam logic [4:0] E_P1_1      = 5'b10110;
    localparam logic [4:0] E_P1_0      = 5'b10100;
    localparam logic [4:0] E_STUFF     = 5'b00100;
    localparam logic [4:0] E_STUFF_END = 5'b00101;
    localparam logic [4:0] E_END       = 5'b00001;

    always #5 clock = ~clock;

    bitstuff_engine dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .src_valid (src_valid),
        .src_bit   (src_bit),
        .src_ready (a_ready),
        .out_bit   (a_ob),
        .out_valid (a_ov),
        .stuff_cnt (a_cnt),
        .pkt_done  (a_done),
        .dbg_state (a_st)
    );

    bitstuff_engine #(
        .NUM_SRC   (2),
        .RUN_LEN   (3),
        .SKIP_BITS (0),
        .STUFF_W   (8)
    ) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .src_valid (src_valid),
        .src_bit   (src_bit),
        .src_ready (b_ready),
        .out_bit   (b_ob),
        .out_valid (b_ov),
        .stuff_cnt (b_cnt),
        .pkt_done  (b_done),
        .dbg_state (b_st)
    );

    function automatic logic [4:0] obs_of(input bit which);
        return which ? {b_ready, b_ov, b_ob, b_done} : {a_ready, a_ov, a_ob, a_done};
    endfunction

    task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: rdy/ov/ob/done got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: stuff_cnt got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: state got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and check the chosen DUT's outputs for that cycle.
    task automatic step(input bit which, input logic [1:0] v, input logic [1:0] b,
                        input logic [4:0] exp, input string tag);
        @(negedge clock);
        src_valid = v;
        src_bit   = b;
        #1;
        check5(tag, obs_of(which), exp);
    endtask

    initial begin
        // Reset: outputs stay low even with both sources valid.
        repeat (2) @(negedge clock);
        src_valid = 2'b11;
        src_bit   = 2'b11;
        #1;
        check5("rst_gate_a", obs_of(1'b0), E_IDLE);
        check5("rst_gate_b", obs_of(1'b1), E_IDLE);
        check_cnt("rst_cnt_a", a_cnt, 8'd0);
        check_st("rst_state_a", a_st, ST_IDLE);
        src_valid = 2'b00;
        src_bit   = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 2'b00, 2'b00, E_IDLE, "idle_a");

        // PID 8'hFF is not stuffed; payload 1111_1111 becomes 111111 0 11.
        for (int i = 0; i < 8; i++) step(0, 2'b01, 2'b01, E_P0_1, "pid_ff");
        for (int i = 0; i < 6; i++) step(0, 2'b01, 2'b01, E_P0_1, "pay_run6");
        step(0, 2'b01, 2'b01, E_STUFF, "stuff_mid");
        step(0, 2'b01, 2'b01, E_P0_1, "pay_b7");
        step(0, 2'b01, 2'b01, E_P0_1, "pay_b8");
        step(0, 2'b00, 2'b00, E_END, "end_ff");
        step(0, 2'b00, 2'b00, E_IDLE, "idle_ff");
        check_cnt("cnt_ff", a_cnt, 8'd1);

        // Payload ends on the sixth 1, so a trailing 0 follows with pkt_done.
        step(0, 2'b01, 2'b00, E_P0_0, "pid00_start");
        check_cnt("cnt_held_at_start", a_cnt, 8'd1);
        step(0, 2'b01, 2'b00, E_P0_0, "pid00_b1");
        check_cnt("cnt_cleared", a_cnt, 8'd0);
        for (int i = 2; i < 8; i++) step(0, 2'b01, 2'b00, E_P0_0, "pid00");
        for (int i = 0; i < 6; i++) step(0, 2'b01, 2'b01, E_P0_1, "trail_run");
        step(0, 2'b00, 2'b00, E_STUFF_END, "trail_stuff");
        step(0, 2'b00, 2'b00, E_IDLE, "trail_idle");
        check_cnt("cnt_trail", a_cnt, 8'd1);

        // Both sources valid together: src0 wins and src1 is ignored until idle.
        for (int i = 0; i < 8; i++) begin
            logic pb;
            pb = i[0];
            step(0, 2'b11, {1'b1, pb}, {2'b01, 1'b1, pb, 1'b0}, "lock_src0");
        end
        step(0, 2'b11, 2'b10, E_P0_0, "lock_pay0");
        step(0, 2'b11, 2'b10, E_P0_0, "lock_pay1");
        step(0, 2'b10, 2'b10, E_END, "src0_end");
        step(0, 2'b10, 2'b10, E_P1_1, "src1_start");
        step(0, 2'b10, 2'b00, E_P1_0, "src1_b1");
        step(0, 2'b11, 2'b11, E_P1_1, "src1_lock");
        step(0, 2'b01, 2'b01, E_END, "src1_skip_end");
        step(0, 2'b00, 2'b00, E_IDLE, "idle_src1");

        // Asynchronous reset in STUFF; the next packet restarts in SKIP.
        for (int i = 0; i < 8; i++) step(0, 2'b01, 2'b01, E_P0_1, "pre_rst_pid");
        for (int i = 0; i < 6; i++) step(0, 2'b01, 2'b01, E_P0_1, "pre_rst_run");
        step(0, 2'b01, 2'b01, E_STUFF, "pre_rst_stuff");
        check_cnt("pre_rst_cnt", a_cnt, 8'd0);
        reset_n = 1'b0;
        #1;
        check5("rst_async", obs_of(1'b0), E_IDLE);
        check_st("rst_async_state", a_st, ST_IDLE);
        @(negedge clock);
        src_valid = 2'b00;
        src_bit   = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 2'b01, 2'b00, E_P0_0, "restart_b0");
        step(0, 2'b01, 2'b01, E_P0_1, "restart_b1");
        check_st("restart_skip", a_st, ST_SKIP);
        check_cnt("restart_cnt", a_cnt, 8'd0);
        step(0, 2'b00, 2'b00, E_END, "restart_end");
        step(0, 2'b00, 2'b00, E_IDLE, "restart_idle");

        // RUN_LEN=3, SKIP_BITS=0: 1111_1111 becomes 1110_1110_11.
        step(1, 2'b00, 2'b00, E_IDLE, "b_idle");
        for (int i = 0; i < 3; i++) step(1, 2'b01, 2'b01, E_P0_1, "b_run1");
        step(1, 2'b01, 2'b01, E_STUFF, "b_stuff1");
        for (int i = 0; i < 3; i++) step(1, 2'b01, 2'b01, E_P0_1, "b_run2");
        check_cnt("b_cnt_mid", b_cnt, 8'd1);
        step(1, 2'b01, 2'b01, E_STUFF, "b_stuff2");
        step(1, 2'b01, 2'b01, E_P0_1, "b_tail7");
        step(1, 2'b01, 2'b01, E_P0_1, "b_tail8");
        step(1, 2'b00, 2'b00, E_END, "b_end");
        step(1, 2'b00, 2'b00, E_IDLE, "b_idle2");
        check_cnt("b_cnt", b_cnt, 8'd2);

        // SKIP_BITS=0 counts the first bit: 0111 ends in a trailing stuff.
        step(1, 2'b01, 2'b00, E_P0_0, "b2_zero");
        for (int i = 0; i < 3; i++) step(1, 2'b01, 2'b01, E_P0_1, "b2_run");
        step(1, 2'b00, 2'b00, E_STUFF_END, "b2_trail");
        step(1, 2'b00, 2'b00, E_IDLE, "b2_idle");
        check_cnt("b2_cnt", b_cnt, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitstuff_engine.md
BITSTUFF_ENGINE -- requirements
Module: bitstuff_engine

Interface
REQ-001 Parameter NUM_SRC, default 2: number of serial bit sources; legal range 1..8.
REQ-002 Parameter RUN_LEN, default 6: consecutive counted 1s that force a stuffed 0; legal range 2..15.
REQ-003 Parameter SKIP_BITS, default 8: leading bits per packet excluded from run counting (PID); legal range 0..255.
REQ-004 Parameter STUFF_W, default 8: width of the per-packet stuff counter.
REQ-005 Ports: clock in 1, single clock; reset_n in 1, asynchronous active-low reset.
REQ-006 Ports: src_valid in NUM_SRC, per-source bit valid; src_bit in NUM_SRC, per-source data bit.
REQ-007 Ports: src_ready out NUM_SRC, per-source bit accepted this cycle.
REQ-008 Ports: out_bit out 1, serial output bit; out_valid out 1, out_bit is meaningful this cycle.
REQ-009 Ports: stuff_cnt out STUFF_W, stuffed bits in current/last packet; pkt_done out 1, one-cycle end-of-packet pulse.

Function
REQ-010 States SHALL be IDLE, SKIP, COUNT, STUFF.
REQ-011 IDLE, no src_valid: outputs 0, state stays IDLE.
REQ-012 IDLE, any src_valid: lock sel = lowest valid index; same cycle src_ready[sel]=1, out_valid=1, out_bit=src_bit[sel]; stuff_cnt cleared; bit index 0 consumed.
REQ-013 Bits with index < SKIP_BITS SHALL pass unmodified, run counter held 0; next state SKIP while index < SKIP_BITS-1, else COUNT; SKIP_BITS=0 goes directly to COUNT and the first bit is counted.
REQ-014 In SKIP/COUNT, src_ready[sel]=src_valid[sel]; out_bit=src_bit[sel] combinationally (zero latency); out_valid=src_valid[sel].
REQ-015 Counted bit 1: run increments; if run reaches RUN_LEN, run clears and next state is STUFF.
REQ-016 Counted bit 0: run clears.
REQ-017 STUFF: out_valid=1, out_bit=0, all src_ready=0, stuff_cnt increments (saturating at all-ones); entered unconditionally, even if src_valid[sel] already dropped (trailing stuff).
REQ-018 STUFF exit: src_valid[sel]=1 -> COUNT with run=0; else -> IDLE and pkt_done=1 that cycle.
REQ-019 SKIP/COUNT with src_valid[sel]=0: packet ends, out_valid=0, pkt_done=1, next state IDLE; valid dropping in SKIP also ends the packet.
REQ-020 Non-selected sources SHALL see src_ready=0 for the whole packet; their valid is ignored until IDLE.
REQ-021 Consecutive packets need one idle cycle of selected valid low; a new packet is accepted in the first IDLE cycle.
REQ-022 stuff_cnt SHALL hold its value after pkt_done until the next packet start.
REQ-023 Bit-index counter SHALL saturate at SKIP_BITS; no wrap.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, run=0, index=0, stuff_cnt=0, sel=0, and all outputs 0, including mid-packet and mid-STUFF.
REQ-025 First rising clock after reset_n deasserts SHALL behave as IDLE.

Structure
REQ-026 Package usb_bs_pkg SHALL hold the state enum and default RUN_LEN/SKIP_BITS constants.
REQ-027 Source selection and lock SHALL be a sub-module bs_src_arbiter (priority pick, hold while locked).
REQ-028 Counter widths SHALL derive via $clog2 of RUN_LEN+1 and SKIP_BITS+1.

Verification
REQ-029 Src0 sends PID 8'hFF then 1111_1111 (defaults) -> PID unstuffed; out = 111111 0 11; stuff_cnt=1.
REQ-030 Src0 payload ends on sixth 1 -> trailing 0 emitted in STUFF after valid drops, pkt_done asserted that cycle.
REQ-031 Src0 and src1 valid same IDLE cycle -> src0 locked, src_ready=2'b01 throughout; src1 served in the packet after the idle gap.
REQ-032 RUN_LEN=3, SKIP_BITS=0, input 1111_1111 -> out 1110_1110_11, stuff_cnt=2, src_ready low in each STUFF cycle.
REQ-033 reset_n pulsed low during STUFF -> out_valid, out_bit, src_ready 0 asynchronously; next packet restarts in SKIP with stuff_cnt=0.
